// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner.
//   NUM_COLS / NUM_ROWS : keypad matrix dimensions
//   CODE_WIDTH          : width of a reported key code (row*4 + col)
//   press_state_e       : press-detection FSM states
// Snapshot bits are laid out column-major (bit = col*4 + row); the helpers
// below turn a snapshot bit position into the row-major key code.
package keypad_pkg;

  localparam int NUM_COLS   = 4;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_KEYS   = NUM_COLS * NUM_ROWS;
  localparam int CODE_WIDTH = 4;

  typedef enum logic {
    WAIT_PRESS   = 1'b0,
    WAIT_RELEASE = 1'b1
  } press_state_e;

  // Snapshot index is {col, row}; key code is {row, col}.
  function automatic logic [CODE_WIDTH-1:0] snap_bit_to_code(input logic [CODE_WIDTH-1:0] idx);
    return {idx[1:0], idx[3:2]};
  endfunction

  function automatic logic is_one_hot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - NUM_KEYS'(1))) == '0);
  endfunction

  // Position of the lowest set bit; only meaningful when v is one-hot.
  function automatic logic [CODE_WIDTH-1:0] lowest_set_index(input logic [NUM_KEYS-1:0] v);
    logic [CODE_WIDTH-1:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_WIDTH'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/Generic_counter.sv
// Generic wrap-around counter with enable and terminal-count trigger.
//   CLK       : clock
//   RESET     : synchronous active-high reset (count -> 0)
//   ENABLE_IN : advance the count this cycle
//   TRIG_OUT  : high when enabled and the count is at COUNTER_MAX (wrap cycle)
//   COUNT     : current count, 0..COUNTER_MAX
module Generic_counter #(
  parameter int COUNTER_WIDTH = 4,
  parameter int COUNTER_MAX   = 9
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     ENABLE_IN,
  output logic                     TRIG_OUT,
  output logic [COUNTER_WIDTH-1:0] COUNT
);

  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(COUNTER_MAX);

  logic [COUNTER_WIDTH-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_count <= '0;
    end else if (ENABLE_IN) begin
      r_count <= (r_count == LAST) ? '0 : r_count + COUNTER_WIDTH'(1);
    end
  end

  assign COUNT    = r_count;
  assign TRIG_OUT = ENABLE_IN && (r_count == LAST);

endmodule

// File: rtl/keypad_debouncer.sv
// Debounces complete 16-key snapshots: the debounced state follows the
// snapshot only after DEBOUNCE_SCANS consecutive identical scans.
//   CLK         : clock
//   RESET       : synchronous active-high reset
//   i_scan_done : snapshot is complete this cycle (one pulse per scan)
//   i_snapshot  : latest full-scan key snapshot (1 = pressed)
//   o_state     : debounced key state
//   o_update    : one-cycle strobe, o_state was (re)loaded on the last edge
module keypad_debouncer
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                i_scan_done,
  input  logic [NUM_KEYS-1:0] i_snapshot,
  output logic [NUM_KEYS-1:0] o_state,
  output logic                o_update
);

  localparam logic [3:0] STABLE_TARGET = 4'(DEBOUNCE_SCANS);

  logic [NUM_KEYS-1:0] r_prev;
  logic [NUM_KEYS-1:0] r_state;
  logic [3:0]          r_stable_cnt;
  logic                r_update;
  logic                w_same;
  logic [3:0]          w_next_cnt;

  // The count saturates so a long-held key keeps refreshing the state
  // without ever wrapping back below the target.
  always_comb begin
    w_same     = (i_snapshot == r_prev);
    w_next_cnt = 4'd1;
    if (w_same) begin
      w_next_cnt = (r_stable_cnt >= STABLE_TARGET) ? STABLE_TARGET : r_stable_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_prev       <= '0;
      r_state      <= '0;
      r_stable_cnt <= '0;
      r_update     <= 1'b0;
    end else begin
      r_update <= 1'b0;
      if (i_scan_done) begin
        r_stable_cnt <= w_next_cnt;
        if (!w_same) r_prev <= i_snapshot;
        if (w_next_cnt == STABLE_TARGET) begin
          r_state  <= i_snapshot;
          r_update <= 1'b1;
        end
      end
    end
  end

  assign o_state  = r_state;
  assign o_update = r_update;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: strobes columns, samples rows, debounces the
// full snapshot and reports single-key presses through a valid/ack handshake.
// Accepted codes are also shifted into a 16-bit display value.
//   CLK       : system clock
//   RESET     : synchronous active-high reset
//   ROW_IN    : keypad rows, active-low, asynchronous
//   COL_OUT   : column strobe, active-low one-hot
//   KEY_CODE  : last accepted key, row*4 + col
//   KEY_VALID : KEY_CODE holds an unacknowledged key
//   KEY_ACK   : consumer acknowledge
//   OVERRUN   : sticky, a press was dropped while KEY_VALID was high
//   VALUE_OUT : last four accepted codes, newest in [3:0]
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DIV_WIDTH      = 17,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [NUM_ROWS-1:0]   ROW_IN,
  output logic [NUM_COLS-1:0]   COL_OUT,
  output logic [CODE_WIDTH-1:0] KEY_CODE,
  output logic                  KEY_VALID,
  input  logic                  KEY_ACK,
  output logic                  OVERRUN,
  output logic [15:0]           VALUE_OUT
);

  logic [NUM_ROWS-1:0]   r_row_meta;
  logic [NUM_ROWS-1:0]   r_row_sync;
  logic [NUM_ROWS-1:0]   w_rows_pressed;
  logic                  w_dwell_trig;
  logic [DIV_WIDTH-1:0]  w_unused_dwell_count;
  logic [1:0]            w_col;
  logic                  w_scan_trig;
  logic [NUM_COLS-1:0]   r_col_out;
  logic [NUM_KEYS-1:0]   r_snapshot;
  logic                  r_scan_done;
  logic [NUM_KEYS-1:0]   w_deb_state;
  logic                  w_deb_update;
  press_state_e          r_state;
  press_state_e          w_next_state;
  logic                  w_event;
  logic [CODE_WIDTH-1:0] w_event_code;
  logic                  r_event;
  logic [CODE_WIDTH-1:0] r_event_code;
  logic [CODE_WIDTH-1:0] r_key_code;
  logic                  r_key_valid;
  logic                  r_overrun;
  logic [15:0]           r_value;

  // Stage 0: row synchronizer. Reset to all-high so nothing looks pressed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_row_meta <= '1;
      r_row_sync <= '1;
    end else begin
      r_row_meta <= ROW_IN;
      r_row_sync <= r_row_meta;
    end
  end

  assign w_rows_pressed = ~r_row_sync;

  Generic_counter #(
    .COUNTER_WIDTH (DIV_WIDTH),
    .COUNTER_MAX   (SCAN_DIV - 1)
  ) u_dwell_counter (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE_IN (1'b1),
    .TRIG_OUT  (w_dwell_trig),
    .COUNT     (w_unused_dwell_count)
  );

  // Its trigger fires on the dwell terminal cycle of column 3: scan complete.
  Generic_counter #(
    .COUNTER_WIDTH (2),
    .COUNTER_MAX   (NUM_COLS - 1)
  ) u_col_counter (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENABLE_IN (w_dwell_trig),
    .TRIG_OUT  (w_scan_trig),
    .COUNT     (w_col)
  );

  // Stage 1: snapshot assembly. Rows are sampled at the end of the dwell,
  // long after the column was driven, so they have settled.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_col_out   <= 4'b1110;
      r_snapshot  <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= w_scan_trig;
      if (w_dwell_trig) begin
        r_col_out                             <= {r_col_out[NUM_COLS-2:0], r_col_out[NUM_COLS-1]};
        r_snapshot[{w_col, 2'b00} +: NUM_ROWS] <= w_rows_pressed;
      end
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_debouncer (
    .CLK         (CLK),
    .RESET       (RESET),
    .i_scan_done (r_scan_done),
    .i_snapshot  (r_snapshot),
    .o_state     (w_deb_state),
    .o_update    (w_deb_update)
  );

  // Stage 2: press FSM, evaluated only when the debounced state refreshes.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state      <= WAIT_PRESS;
      r_event      <= 1'b0;
      r_event_code <= '0;
    end else begin
      r_state      <= w_next_state;
      r_event      <= w_event;
      r_event_code <= w_event_code;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_event      = 1'b0;
    w_event_code = snap_bit_to_code(lowest_set_index(w_deb_state));
    if (w_deb_update) begin
      case (r_state)
        WAIT_PRESS: begin
          if (is_one_hot(w_deb_state)) begin
            w_event      = 1'b1;
            w_next_state = WAIT_RELEASE;
          end else if (w_deb_state != '0) begin
            w_next_state = WAIT_RELEASE;
          end
        end
        WAIT_RELEASE: begin
          if (w_deb_state == '0) w_next_state = WAIT_PRESS;
        end
        default: w_next_state = WAIT_PRESS;
      endcase
    end
  end

  // Stage 3: handshake and output registers. An ack in the same cycle as
  // an event frees the slot, so the new key is accepted rather than dropped.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_value     <= '0;
    end else if (r_event) begin
      if (!r_key_valid || KEY_ACK) begin
        r_key_code  <= r_event_code;
        r_key_valid <= 1'b1;
        r_value     <= {r_value[11:0], r_event_code};
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (KEY_ACK && r_key_valid) begin
      r_key_valid <= 1'b0;
    end
  end

  assign COL_OUT   = r_col_out;
  assign KEY_CODE  = r_key_code;
  assign KEY_VALID = r_key_valid;
  assign OVERRUN   = r_overrun;
  assign VALUE_OUT = r_value;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_SCANS = 2 (16-cycle scan).
// A behavioural keypad pulls a row low while a pressed key's column is strobed.
// Expected key reports are queued when presses are driven and compared when the
// DUT reports a key (KEY_VALID rising, or code/value changing while valid).
module tb_keypad_scanner;

  localparam int SCAN_CYC = 16;
  localparam int LAT      = 2 * SCAN_CYC + 3;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] value;
    logic        ovr;
    int          cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  ROW_IN;
  logic [3:0]  COL_OUT;
  logic [3:0]  KEY_CODE;
  logic        KEY_VALID;
  logic        KEY_ACK = 1'b0;
  logic        OVERRUN;
  logic [15:0] VALUE_OUT;

  logic [15:0] pressed = '0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        sb_q[$];

  logic [15:0] model_value = '0;
  logic        model_valid = 1'b0;
  logic        model_ovr = 1'b0;

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DIV_WIDTH      (2),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ROW_IN    (ROW_IN),
    .COL_OUT   (COL_OUT),
    .KEY_CODE  (KEY_CODE),
    .KEY_VALID (KEY_VALID),
    .KEY_ACK   (KEY_ACK),
    .OVERRUN   (OVERRUN),
    .VALUE_OUT (VALUE_OUT)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (RESET) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Key code = row*4 + col.
  always_comb begin
    ROW_IN = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !COL_OUT[c]) ROW_IN[r] = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    model_value = '0;
    model_valid = 1'b0;
    model_ovr   = 1'b0;
  endtask

  task automatic run_scans(input logic [15:0] mask, input int n);
    pressed = mask;
    repeat (SCAN_CYC * n) @(negedge CLK);
  endtask

  // One scan with a single-cycle ack at its start; keys stay as they are.
  task automatic ack_scan();
    KEY_ACK = 1'b1;
    @(negedge CLK);
    KEY_ACK = 1'b0;
    model_valid = 1'b0;
    repeat (SCAN_CYC - 1) @(negedge CLK);
  endtask

  task automatic expect_press(input logic [3:0] code, input logic ack_same);
    if (!model_valid || ack_same) begin
      model_value = {model_value[11:0], code};
      model_valid = 1'b1;
      sb_q.push_back('{code: code, value: model_value, ovr: model_ovr, cyc: cyc + LAT});
    end else begin
      model_ovr = 1'b1;
    end
  endtask

  // Report monitor.
  initial begin
    logic        prev_valid;
    logic [3:0]  prev_code;
    logic [15:0] prev_value;
    exp_t        e;
    prev_valid = 1'b0;
    prev_code  = '0;
    prev_value = '0;
    forever begin
      @(negedge CLK);
      if (!RESET && KEY_VALID &&
          (!prev_valid || KEY_CODE != prev_code || VALUE_OUT != prev_value)) begin
        check("report_expected", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("report_code", 32'(KEY_CODE), 32'(e.code));
          check("report_value", 32'(VALUE_OUT), 32'(e.value));
          check("report_overrun", 32'(OVERRUN), 32'(e.ovr));
          check("report_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_valid = KEY_VALID;
      prev_code  = KEY_CODE;
      prev_value = VALUE_OUT;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] col_exp;
    int         base;

    // Reset release and idle column sweep over two scans.
    do_reset();
    for (int i = 0; i < 2 * SCAN_CYC; i++) begin
      col_exp = 4'b1111;
      col_exp[(cyc / 4) % 4] = 1'b0;
      check("col_out", 32'(COL_OUT), 32'(col_exp));
      if (i % 8 == 0) begin
        check("idle_valid", 32'(KEY_VALID), 32'd0);
        check("idle_code", 32'(KEY_CODE), 32'd0);
        check("idle_value", 32'(VALUE_OUT), 32'd0);
        check("idle_overrun", 32'(OVERRUN), 32'd0);
      end
      @(negedge CLK);
    end

    // Row 2 / col 1 held for five scans: one report, code 9.
    expect_press(4'd9, 1'b0);
    run_scans(16'(1) << 9, 5);
    run_scans('0, 2);
    ack_scan();
    check("ack_clears_valid", 32'(KEY_VALID), 32'd0);

    // Bounce on alternate scans, then a steady hold of code 6.
    for (int i = 0; i < 3; i++) begin
      run_scans(16'(1) << 6, 1);
      run_scans('0, 1);
    end
    expect_press(4'd6, 1'b0);
    run_scans(16'(1) << 6, 2);
    run_scans('0, 2);
    ack_scan();

    // Two keys together produce nothing; then code 3.
    run_scans((16'(1) << 0) | (16'(1) << 5), 3);
    run_scans('0, 2);
    expect_press(4'd3, 1'b0);
    run_scans(16'(1) << 3, 3);
    check("two_key_value", 32'(VALUE_OUT), 32'h0963);

    // Reset while KEY_VALID is high and code 3 is still held.
    check("pre_reset_valid", 32'(KEY_VALID), 32'd1);
    do_reset();
    check("post_reset_valid", 32'(KEY_VALID), 32'd0);
    check("post_reset_code", 32'(KEY_CODE), 32'd0);
    check("post_reset_value", 32'(VALUE_OUT), 32'd0);
    check("post_reset_col", 32'(COL_OUT), 32'b1110);
    expect_press(4'd3, 1'b0);
    run_scans(16'(1) << 3, 2);
    run_scans('0, 2);
    ack_scan();

    // Overrun: code 4 unacknowledged, then code 7 is dropped.
    do_reset();
    expect_press(4'd4, 1'b0);
    run_scans(16'(1) << 4, 2);
    run_scans('0, 2);
    expect_press(4'd7, 1'b0);
    run_scans(16'(1) << 7, 2);
    run_scans('0, 2);
    check("ovr_code", 32'(KEY_CODE), 32'd4);
    check("ovr_flag", 32'(OVERRUN), 32'd1);
    check("ovr_value", 32'(VALUE_OUT), 32'h0004);
    check("ovr_valid", 32'(KEY_VALID), 32'd1);
    ack_scan();
    check("ovr_ack_valid", 32'(KEY_VALID), 32'd0);
    expect_press(4'd7, 1'b0);
    run_scans(16'(1) << 7, 2);
    run_scans('0, 2);
    check("ovr_sticky", 32'(OVERRUN), 32'd1);
    check("ovr_value2", 32'(VALUE_OUT), 32'h0047);

    // Ack in the same cycle as a new event while KEY_VALID is high.
    do_reset();
    expect_press(4'd2, 1'b0);
    run_scans(16'(1) << 2, 2);
    run_scans('0, 2);
    base = cyc;
    pressed = 16'(1) << 10;
    expect_press(4'd10, 1'b1);
    while (cyc < base + LAT - 1) @(negedge CLK);
    KEY_ACK = 1'b1;
    @(negedge CLK);
    KEY_ACK = 1'b0;
    check("same_ack_valid", 32'(KEY_VALID), 32'd1);
    check("same_ack_code", 32'(KEY_CODE), 32'd10);
    check("same_ack_overrun", 32'(OVERRUN), 32'd0);
    while (cyc < base + 3 * SCAN_CYC) @(negedge CLK);
    run_scans('0, 2);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
